load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 2048, data-memory size in bytes; addresses >= MEM_BYTES are out of range.
REQ-002 SHALL have ports, in this order:
 clk  in  1  clock, rising-edge logic
 rst_n  in  1  reset, asynchronous, active-low
 req_valid  in  1  execute stage presents a memory request
 req_ready  out  1  unit accepts the request this cycle
 req_we  in  1  1 = store, 0 = load
 req_func3  in  3  RV32I width code: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101
 req_addr  in  32  byte address
 req_wdata  in  32  store data
 req_rd  in  5  load destination register
 mem_addr  out  32  data-memory address
 mem_wdata  out  32  data-memory write data
 mem_func3  out  3  data-memory width code
 mem_rd_en  out  1  data-memory read enable
 mem_wr_en  out  1  data-memory write enable; the memory writes on the falling clock edge
 mem_rdata  in  32  combinational read data from memory, already extended
 resp_valid  out  1  response to writeback stage
 resp_ready  in  1  writeback stage accepts the response
 resp_rd  out  5  destination register; 0 for stores
 resp_data  out  32  load result; 0 for stores and faults
 resp_fault  out  1  request faulted and performed no memory access

Function
REQ-003 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-004 req_ready SHALL be 1 in IDLE, equal to resp_ready in RESP, and 0 in ACCESS.
REQ-005 On a rising edge with req_valid && req_ready, the unit SHALL latch we, func3, addr, wdata and rd.
REQ-006 After that edge, a non-faulting request SHALL go to ACCESS and a faulting request SHALL go straight to RESP.
REQ-007 In ACCESS, and only in ACCESS, mem_rd_en SHALL equal !we and mem_wr_en SHALL equal we.
REQ-008 In ACCESS, mem_addr, mem_wdata and mem_func3 SHALL come from the latched request; the enables SHALL be decoded from state, not registered.
REQ-009 ACCESS SHALL last exactly one cycle. On its closing rising edge the unit SHALL capture mem_rdata for a load, or 0 for a store, into resp_data, and go to RESP.
REQ-010 Latency: resp_valid SHALL rise 2 edges after acceptance for a non-faulting request and 1 edge after acceptance for a faulting request.
REQ-011 In RESP, resp_valid, resp_rd, resp_data and resp_fault SHALL hold steady until a rising edge with resp_ready=1.
REQ-012 On that edge, the unit SHALL accept a new request if req_valid=1 (going to ACCESS or RESP per REQ-006), else go to IDLE.
REQ-013 Back-to-back throughput SHALL be one request per 2 cycles.
REQ-014 Fault conditions (each faults):
 - addr >= MEM_BYTES
 - store with func3 > 010
 - load with func3 equal to 011, 110 or 111
 - misaligned access, where enabled per REQ-020
REQ-015 A faulting request SHALL never assert mem_rd_en or mem_wr_en.
REQ-016 The unit SHALL not modify read data; sign and zero extension belong to the memory.

Reset
REQ-017 While rst_n=0, the state SHALL be IDLE, with resp_valid, resp_fault, mem_rd_en and mem_wr_en all 0, and resp_rd, resp_data and the latched request registers all 0.
REQ-018 Reset asserted during ACCESS SHALL drop mem_wr_en immediately, cancelling a store whose falling edge has not yet occurred. Reset asserted during RESP SHALL discard the pending response.
REQ-019 After reset deassertion, the first rising edge SHALL be able to accept a request.

Configuration
REQ-020 The macro MISALIGN_TRAP_EN controls misaligned accesses:
 - Defined: halfword access with addr[0]=1, or word access with addr[1:0]!=00, SHALL fault.
 - Undefined: no misalignment fault; mem_addr SHALL be aligned down (halfword clears bit 0, word clears bits 1:0). Byte accesses are never affected.

Verification
REQ-021 SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 with rd=5 -> one mem_wr_en pulse, then resp_data=0xDEADBEEF, resp_rd=5, resp_fault=0, 2 edges after acceptance.
REQ-022 LB addr=0x13 with memory returning 0xFFFFFFEF -> resp_data=0xFFFFFFEF; req_ready=0 during ACCESS.
REQ-023 LW addr=0x12:
 - macro defined -> resp_fault=1 1 edge after acceptance, mem_rd_en never 1.
 - macro undefined -> mem_addr=0x10.
REQ-024 LW addr=0x800 (MEM_BYTES=2048) -> fault. SB func3=011 -> fault.
REQ-025 Hold resp_ready=0 for 3 cycles with a second request waiting -> response stable and second request not accepted. Raise resp_ready -> second request accepted on the same edge.
REQ-026 Drive rst_n low mid-ACCESS of an SW -> mem_wr_en falls immediately, memory unchanged, state IDLE.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
// Memory-stage sequencer between the execute stage and a byte-addressed data
// memory. It accepts one request, runs a single-cycle memory access, and then
// holds the response until writeback takes it. Requests that would fault are
// answered directly and never touch memory.
//
// Configuration macro: MISALIGN_TRAP_EN
//   defined   : misaligned halfword/word accesses fault
//   undefined : misaligned accesses are aligned down on mem_addr
//
// Ports
//   clk, rst_n                  clock (rising edge) / async active-low reset
//   req_valid, req_ready        request handshake from execute
//   req_we, req_func3           store flag and RV32I width code
//   req_addr, req_wdata, req_rd byte address, store data, load destination
//   mem_addr, mem_wdata         data-memory address and write data
//   mem_func3                   data-memory width code
//   mem_rd_en, mem_wr_en        enables, asserted only during ACCESS
//   mem_rdata                   read data, already extended by the memory
//   resp_valid, resp_ready      response handshake to writeback
//   resp_rd, resp_data          destination register and load result
//   resp_fault                  request faulted, no memory access was made
//
// state  | meaning
// IDLE   | no request in flight, ready to accept
// ACCESS | memory enables asserted for the latched request (one cycle)
// RESP   | response presented, held until resp_ready

module load_store_unit #(
    parameter int MEM_BYTES = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_func3,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [4:0]  resp_rd,
    output logic [31:0] resp_data,
    output logic        resp_fault
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    logic        lat_we;
    logic [2:0]  lat_func3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [4:0]  lat_rd;

    logic        accept;
    logic        range_fault;
    logic        width_fault;
    logic        misalign_fault;
    logic        req_fault;

    assign req_ready = (state == IDLE) || ((state == RESP) && resp_ready);
    assign accept    = req_valid && req_ready;

    assign range_fault = (req_addr >= 32'(MEM_BYTES));

    // Stores only have SB/SH/SW; loads additionally have LBU/LHU.
    assign width_fault = req_we ? (req_func3 > 3'b010)
                                : ((req_func3 == 3'b011) || (req_func3[2:1] == 2'b11));

`ifdef MISALIGN_TRAP_EN
    logic req_half;
    logic req_word;

    assign req_half       = (req_func3[1:0] == 2'b01);
    assign req_word       = (req_func3[1:0] == 2'b10);
    assign misalign_fault = (req_half && req_addr[0]) ||
                            (req_word && (req_addr[1:0] != 2'b00));
    assign mem_addr       = lat_addr;
`else
    logic lat_half;
    logic lat_word;

    assign misalign_fault = 1'b0;
    assign lat_half       = (lat_func3[1:0] == 2'b01);
    assign lat_word       = (lat_func3[1:0] == 2'b10);
    // Align down: halfword clears bit 0, word clears bits 1:0.
    assign mem_addr       = {lat_addr[31:2],
                             lat_addr[1] & ~lat_word,
                             lat_addr[0] & ~(lat_half | lat_word)};
`endif

    assign req_fault = range_fault || width_fault || misalign_fault;

    assign mem_wdata = lat_wdata;
    assign mem_func3 = lat_func3;
    // Decoded from state so an async reset drops them immediately.
    assign mem_rd_en = (state == ACCESS) && !lat_we;
    assign mem_wr_en = (state == ACCESS) &&  lat_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            lat_func3  <= 3'd0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_rd     <= 5'd0;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rd    <= 5'd0;
            resp_data  <= 32'd0;
        end else if (accept) begin
            lat_we    <= req_we;
            lat_func3 <= req_func3;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_rd    <= req_rd;
            if (req_fault) begin
                // Faults skip ACCESS and respond on the very next cycle.
                state      <= RESP;
                resp_valid <= 1'b1;
                resp_fault <= 1'b1;
                resp_data  <= 32'd0;
                resp_rd    <= req_we ? 5'd0 : req_rd;
            end else begin
                state      <= ACCESS;
                resp_valid <= 1'b0;
                resp_fault <= 1'b0;
            end
        end else begin
            case (state)
                ACCESS: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_fault <= 1'b0;
                    resp_rd    <= lat_we ? 5'd0  : lat_rd;
                    resp_data  <= lat_we ? 32'd0 : mem_rdata;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_fault <= 1'b0;
                    end
                end
                IDLE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases followed by a randomized run,
// checked against a byte-array reference model of memory and a rule-based
// model of faulting, alignment and extension.

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_func3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_func3;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        resp_fault;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(2048)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_func3  (req_func3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_func3  (mem_func3),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rd    (resp_rd),
        .resp_data  (resp_data),
        .resp_fault (resp_fault)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- data memory (environment) ----------------
    logic [7:0]  dmem   [0:2047];
    logic [7:0]  shadow [0:2047];
    logic [10:0] widx;
    logic [10:0] ri;
    logic [7:0]  rb0, rb1, rb2, rb3;

    function automatic logic [7:0] seed_byte(input int i);
        if (i == 19) return 8'hEF;
        return 8'((i * 73 + 41) ^ (i >> 3));
    endfunction

    initial begin
        for (int i = 0; i < 2048; i++) dmem[i] = seed_byte(i);
        forever begin
            @(negedge clk);
            if (mem_wr_en) begin
                widx = mem_addr[10:0];
                dmem[widx] = mem_wdata[7:0];
                if (mem_func3[1:0] != 2'b00) dmem[widx + 11'd1] = mem_wdata[15:8];
                if (mem_func3[1:0] == 2'b10) begin
                    dmem[widx + 11'd2] = mem_wdata[23:16];
                    dmem[widx + 11'd3] = mem_wdata[31:24];
                end
            end
        end
    end

    always_comb begin
        ri  = mem_addr[10:0];
        rb0 = dmem[ri];
        rb1 = dmem[ri + 11'd1];
        rb2 = dmem[ri + 11'd2];
        rb3 = dmem[ri + 11'd3];
        case (mem_func3)
            3'b000:  mem_rdata = {{24{rb0[7]}}, rb0};
            3'b001:  mem_rdata = {{16{rb1[7]}}, rb1, rb0};
            3'b100:  mem_rdata = {24'd0, rb0};
            3'b101:  mem_rdata = {16'd0, rb1, rb0};
            default: mem_rdata = {rb3, rb2, rb1, rb0};
        endcase
    end

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic m_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic bad;
        bad = (a >= 32'd2048);
        if (we && !(f3 inside {3'd0, 3'd1, 3'd2})) bad = 1'b1;
        if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) bad = 1'b1;
`ifdef MISALIGN_TRAP_EN
        if (a % 32'(m_size(f3)) != 0) bad = 1'b1;
`endif
        return bad;
    endfunction

    function automatic logic [31:0] m_align(input logic [2:0] f3, input logic [31:0] a);
        return a - (a % 32'(m_size(f3)));
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v;
        int sz;
        sz = m_size(f3);
        v = 32'd0;
        for (int k = 0; k < sz; k++) v = v | (32'(shadow[int'(a) + k]) << (8 * k));
        if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    logic        e_fault, e_we;
    logic [2:0]  e_f3;
    logic [31:0] e_addr, e_wdata, e_data;
    logic [4:0]  e_rd;
    int          e_lat;

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, output int waited);
        req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
        req_valid = 1'b1;
        resp_ready = 1'b1;
        waited = 0;
        #1;
        while (!req_ready && waited < 8) begin
            @(posedge clk);
            #1;
            waited++;
        end
        e_fault = m_fault(we, f3, a);
        e_we    = we;
        e_f3    = f3;
        e_addr  = m_align(f3, a);
        e_wdata = wd;
        e_rd    = we ? 5'd0 : rd;
        e_data  = (e_fault || we) ? 32'd0 : m_load(e_addr, f3);
        e_lat   = e_fault ? 1 : 2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        resp_ready = 1'b0;
    endtask

    task automatic wait_resp();
        int edges;
        int acc;
        edges = 0;
        acc = 0;
        while (edges < 6) begin
            @(negedge clk);
            #1;
            edges++;
            if (mem_rd_en || mem_wr_en) begin
                acc++;
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_dir", 32'(mem_wr_en), 32'(e_we));
                chk("mem_func3", 32'(mem_func3), 32'(e_f3));
                chk("rdy_access", 32'(req_ready), 32'd0);
                if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
            end
            if (resp_valid) break;
        end
        chk("latency", 32'(edges), 32'(e_lat));
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_fault", 32'(resp_fault), 32'(e_fault));
        chk("resp_data", resp_data, e_data);
        chk("resp_rd", 32'(resp_rd), 32'(e_rd));
        chk("access_cnt", 32'(acc), e_fault ? 32'd0 : 32'd1);
        if (e_we && !e_fault)
            for (int k = 0; k < m_size(e_f3); k++) shadow[int'(e_addr) + k] = e_wdata[8*k +: 8];
    endtask

    task automatic hold_resp(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_data", resp_data, e_data);
            chk("hold_rd", 32'(resp_rd), 32'(e_rd));
            chk("hold_fault", 32'(resp_fault), 32'(e_fault));
            chk("hold_rdy", 32'(req_ready), 32'd0);
            chk("hold_noacc", 32'(mem_rd_en | mem_wr_en), 32'd0);
        end
    endtask

    task automatic release_resp();
        req_valid = 1'b0;
        resp_ready = 1'b1;
        #1;
        chk("rdy_resp", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("to_idle", 32'(resp_valid), 32'd0);
        chk("idle_rdy", 32'(req_ready), 32'd1);
    endtask

    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd, input int hold, input bit rel);
        int waited;
        issue(we, f3, a, wd, rd, waited);
        chk("accept_wait", 32'(waited), 32'd0);
        wait_resp();
        hold_resp(hold);
        if (rel) release_resp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        int diff;
        logic [2:0] valid_f3 [0:4];
        logic [2:0] f3;
        logic [31:0] a;
        int r;
        valid_f3[0] = 3'd0; valid_f3[1] = 3'd1; valid_f3[2] = 3'd2;
        valid_f3[3] = 3'd4; valid_f3[4] = 3'd5;
        for (int i = 0; i < 2048; i++) shadow[i] = seed_byte(i);

        // reset state
        #12;
        chk("rst_rdy", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_fault", 32'(resp_fault), 32'd0);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_resp_rd", 32'(resp_rd), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // LB with a negative byte, then SW/LW round trip
        txn(1'b0, 3'b000, 32'h13, 32'd0, 5'd2, 0, 1'b1);
        chk("lb_sext", resp_data, 32'hFFFF_FFEF);
        txn(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 5'd4, 0, 1'b1);
        txn(1'b0, 3'b010, 32'h10, 32'd0, 5'd5, 0, 1'b1);
        chk("lw_roundtrip", resp_data, 32'hDEAD_BEEF);

        // misaligned word, out of range, bad store width
        txn(1'b0, 3'b010, 32'h12, 32'd0, 5'd6, 1, 1'b1);
        txn(1'b0, 3'b010, 32'h800, 32'd0, 5'd7, 0, 1'b1);
        txn(1'b0, 3'b000, 32'h7FF, 32'd0, 5'd8, 0, 1'b1);
        txn(1'b1, 3'b011, 32'h40, 32'h1111_2222, 5'd9, 0, 1'b1);

        // backpressure with a second request waiting
        txn(1'b0, 3'b010, 32'h20, 32'd0, 5'd7, 0, 1'b0);
        req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h24; req_rd = 5'd9;
        req_valid = 1'b1;
        hold_resp(3);
        issue(1'b0, 3'b010, 32'h24, 32'd0, 5'd9, waited);
        chk("b2b_accept", 32'(waited), 32'd0);
        wait_resp();
        release_resp();

        // reset in the middle of a store's ACCESS cycle
        issue(1'b1, 3'b010, 32'h40, 32'h1234_5678, 5'd3, waited);
        chk("sw_wr_en", 32'(mem_wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_wr_drop", 32'(mem_wr_en), 32'd0);
        chk("rst_idle_rdy", 32'(req_ready), 32'd1);
        chk("rst_no_resp", 32'(resp_valid), 32'd0);
        chk("rst_lat_addr", mem_addr, 32'd0);
        chk("rst_lat_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        #1;
        for (int k = 0; k < 4; k++) chk("store_cancel", 32'(dmem[64 + k]), 32'(shadow[64 + k]));
        rst_n = 1'b1;
        txn(1'b0, 3'b010, 32'h40, 32'd0, 5'd10, 0, 1'b1);

        // randomized traffic
        for (int t = 0; t < 80; t++) begin
            r = int'($urandom_range(0, 9));
            f3 = (r < 8) ? valid_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
            r = int'($urandom_range(0, 7));
            if (r == 0)      a = 32'(2040 + $urandom_range(0, 15));
            else if (r == 1) a = $urandom;
            else             a = 32'($urandom_range(0, 2047));
            txn(1'($urandom_range(0, 1)), f3, a, $urandom, 5'($urandom_range(0, 31)),
                int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
        release_resp();

        diff = 0;
        for (int i = 0; i < 2048; i++) if (dmem[i] !== shadow[i]) diff++;
        chk("mem_image", 32'(diff), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
